data_mem_loader: RTL and testbench
==================================

# data_mem_loader

- Sequential loader between the testbench/host byte stream and `data_mem`.
- Accepts a byte stream over a valid/ready handshake and packs every four bytes into a 32-bit word.
- Writes each word into `data_mem` through its `Memwrite` port at consecutive word addresses.
- Holds the CPU in reset-like stall (`cpu_hold`) until the whole array is loaded, then releases it so the program can compute `max`/`max_index`.

## Interface

- `BASE_ADDR`, 1000, byte address of the first word written.
- `WORD_COUNT`, 20, number of 32-bit words per load, range 1..65535.
- `clk`  in  1  system clock, all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a new load; sampled only in IDLE and DONE.
- `in_valid`  in  1  byte on `in_data` is valid.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_address`  out  32  drives `data_mem` address.
- `mem_write_data`  out  32  drives `data_mem` write_data.
- `mem_write`  out  1  drives `data_mem` Memwrite.
- `cpu_hold`  out  1  high while the CPU must not run.
- `busy`  out  1  high in COLLECT or WRITE.
- `done`  out  1  high in DONE.
- `words_written`  out  16  count of words committed in the current load.

## Operation

- States:
  - IDLE: after reset.
  - COLLECT: accepting bytes.
  - WRITE: one-cycle memory commit.
  - DONE.
- IDLE: `in_ready`=0, `cpu_hold`=1. On `start`, go to COLLECT with byte index=0, word index=0, `words_written`=0.
- COLLECT:
  - `in_ready`=1.
  - Each handshake (`in_valid`&`in_ready` at the rising edge) stores `in_data` into `mem_write_data[8k+7:8k]`, where k is the byte index 0..3. The first byte therefore lands at the lowest byte address.
  - After the byte with k=3, go to WRITE.
  - `in_valid`=0 stalls indefinitely with no state change.
- WRITE:
  - `mem_write`=1 for exactly one cycle; `in_ready`=0.
  - `mem_address`=BASE_ADDR+4*word_index, held stable for the whole cycle.
  - At the end of the cycle, increment `words_written` and the word index, and clear the byte index.
  - If the new count equals WORD_COUNT, go to DONE; otherwise go to COLLECT.
- DONE: `done`=1, `cpu_hold`=0, `in_ready`=0. Address, data and `words_written` hold their last values. `start` restarts exactly as from IDLE.
- `start` during COLLECT/WRITE is ignored.
- Address arithmetic is 32-bit unsigned with wrap. The address is registered, not recomputed combinationally from `in_data`.
- Bytes presented while `in_ready`=0 are not consumed.

## Timing

- Reset values (asynchronous, take effect immediately on `rst`):
  - State=IDLE.
  - `in_ready`=0, `mem_write`=0, `busy`=0, `done`=0.
  - `cpu_hold`=1.
  - `mem_address`=BASE_ADDR, `mem_write_data`=0, `words_written`=0.
- Throughput: best case 5 cycles per word (4 accept cycles + 1 write cycle).
- Latency from the 4th-byte handshake edge to `mem_write` high: 1 cycle. The write commits on the following edge.
- `done` and `cpu_hold` fall/rise together on the edge that leaves WRITE for the last word. The CPU sees its first unheld cycle one cycle after the last write commits, so the written data is visible to it.
- `rst` asserted mid-load aborts the load and returns to IDLE. Words already written stay in memory. A partially packed word is discarded and `mem_write` is never issued for it.
- `start` and the final `mem_write` never coincide, because `start` is ignored in WRITE.

## Configuration

- `LOADER_CHECKSUM_EN` defined:
  - Adds output `checksum` (32 bits): the wrapping 32-bit sum of every word committed in the current load.
  - Reset value 0; cleared on accepted `start`; updated on the edge ending each WRITE.
  - Valid in DONE.
- Undefined: the `checksum` port and its adder are absent; all other behaviour is identical.

## Test plan

- Reset: assert `rst` mid-cycle -> all outputs at the reset values immediately, without waiting for a clock edge.
- WORD_COUNT=2, BASE_ADDR=1000, stream 0x11,0x22,0x33,0x44,0x05,0x00,0x00,0x00 with `in_valid` constant:
  - One write to 1000 with data 0x44332211.
  - One write to 1004 with data 0x00000005.
  - `done`=1 on cycle 10 after `start`.
  - `data_mem` bytes 1000..1003 = 11,22,33,44.
- Backpressure: random `in_valid` gaps in the same stream -> identical writes and data, with `mem_write` asserted exactly twice.
- Ignored start: `start` pulsed during COLLECT after byte 2 -> byte index is not reset and the word is still 0x44332211.
- Reset mid-load: `rst` after 6 bytes with WORD_COUNT=2 -> exactly one write (address 1000); after reset `cpu_hold`=1 and `words_written`=0. A new `start` reloads from 1000.
- With `LOADER_CHECKSUM_EN`: words 0xFFFFFFFF and 0x00000002 -> `checksum`=0x00000001 in DONE. A restart clears it to 0.

Source files
------------

// File: rtl/data_mem_loader.sv
// data_mem_loader
//
// Sequential loader that sits between a host byte stream and data_mem.
// Bytes arrive over a valid/ready handshake and are packed little-endian
// (first byte in bits [7:0]) into 32-bit words. Each completed word is
// committed to data_mem with a single-cycle Memwrite pulse at consecutive
// word addresses starting at BASE_ADDR. The CPU is held off (cpu_hold) until
// the whole array has been written.
//
// Parameters:
//   BASE_ADDR      byte address of the first word written
//   WORD_COUNT     words per load, 1..65535
//
// Ports:
//   clk            system clock, rising-edge
//   rst            asynchronous active-high reset
//   start          begins a new load (honoured only in IDLE and DONE)
//   in_valid       in_data carries a valid byte
//   in_data        stream byte
//   in_ready       loader accepts a byte this cycle
//   mem_address    data_mem address (registered)
//   mem_write_data data_mem write data (packed word)
//   mem_write      data_mem Memwrite strobe
//   cpu_hold       CPU must not run while high
//   busy           load in progress (COLLECT or WRITE)
//   done           load complete
//   words_written  words committed in the current load
//   checksum       wrapping sum of committed words (LOADER_CHECKSUM_EN only)
//
// Build option:
//   LOADER_CHECKSUM_EN  adds the checksum output and its accumulator.

module data_mem_loader #(
  parameter logic [31:0] BASE_ADDR  = 32'd1000,
  parameter int unsigned WORD_COUNT = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic [15:0] words_written
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0] checksum
`endif
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_WRITE   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [15:0] LAST_COUNT = 16'(WORD_COUNT);

  logic [1:0]  state_q, state_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [15:0] count_q, count_d;
  logic [15:0] count_inc;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
`endif

  // Next-state logic. The word index is implicit: the address register
  // advances by one word after every commit except the last, so in DONE
  // it still points at the final word written.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    addr_d     = addr_q;
    data_d     = data_q;
    count_d    = count_q;
    count_inc  = count_q + 16'd1;
`ifdef LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_COLLECT;
          byte_idx_d = 2'd0;
          count_d    = 16'd0;
          addr_d     = BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
          sum_d      = 32'd0;
`endif
        end
      end

      ST_COLLECT: begin
        // in_ready is high throughout COLLECT, so in_valid alone is the handshake.
        if (in_valid) begin
          data_d[{byte_idx_q, 3'b000} +: 8] = in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        count_d    = count_inc;
        byte_idx_d = 2'd0;
`ifdef LOADER_CHECKSUM_EN
        sum_d      = sum_q + data_q;
`endif
        if (count_inc == LAST_COUNT) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_COLLECT;
          addr_d  = addr_q + 32'd4;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset drops any partially packed word so it can never
  // be written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      byte_idx_q <= 2'd0;
      addr_q     <= BASE_ADDR;
      data_q     <= 32'd0;
      count_q    <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      count_q    <= count_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  // Outputs decode directly from the state register so they follow the
  // asynchronous reset immediately.
  assign in_ready       = (state_q == ST_COLLECT);
  assign mem_write      = (state_q == ST_WRITE);
  assign busy           = (state_q == ST_COLLECT) || (state_q == ST_WRITE);
  assign done           = (state_q == ST_DONE);
  assign cpu_hold       = (state_q != ST_DONE);
  assign mem_address    = addr_q;
  assign mem_write_data = data_q;
  assign words_written  = count_q;
`ifdef LOADER_CHECKSUM_EN
  assign checksum       = sum_q;
`endif

endmodule

// File: tb/tb_data_mem_loader.sv
// tb_data_mem_loader
//
// Self-checking bench for data_mem_loader built with WORD_COUNT=2 and
// BASE_ADDR=1000. Loads are described in a vector table; expected memory
// writes go into a scoreboard queue as the completing byte is driven and are
// popped by a monitor when mem_write appears. A byte-wide model of data_mem
// captures the writes so byte ordering can be checked. Hand-written
// sequences cover asynchronous reset and a reset in the middle of a load.
// Build with LOADER_CHECKSUM_EN defined to also check the checksum output.

module tb_data_mem_loader;

  localparam logic [31:0] BASE  = 32'd1000;
  localparam int          WORDS = 2;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic [15:0] words_written;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  typedef struct {
    logic [63:0] stream;       // byte n of the stream in bits [8n+7:8n]
    int          gapPct;       // chance of an in_valid gap per cycle
    int          startPulseAt; // byte index at which a stray start is pulsed, -1 none
    int          expDoneCycle; // cycles from start edge to done, -1 unchecked
    logic [31:0] expWord0;
    logic [31:0] expWord1;
    logic [31:0] expChecksum;
  } vec_t;

  vec_t vecs[5];

  int assertCount = 0;
  int failCount   = 0;
  int writeCount  = 0;

  logic [63:0] expQ[$];
  logic [63:0] monExp;
  logic [7:0]  memModel [int unsigned];

  data_mem_loader #(
    .BASE_ADDR (BASE),
    .WORD_COUNT(WORDS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .mem_address   (mem_address),
    .mem_write_data(mem_write_data),
    .mem_write     (mem_write),
    .cpu_hold      (cpu_hold),
    .busy          (busy),
    .done          (done),
    .words_written (words_written)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum      (checksum)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] readWord(input logic [31:0] addr);
    return {memModel[addr + 32'd3], memModel[addr + 32'd2],
            memModel[addr + 32'd1], memModel[addr]};
  endfunction

  // Write monitor: models data_mem byte storage and checks each write
  // against the oldest scoreboard entry.
  always @(negedge clk) begin
    if (rst === 1'b0 && mem_write === 1'b1) begin
      writeCount++;
      for (int i = 0; i < 4; i++) begin
        memModel[mem_address + 32'(i)] = mem_write_data[8*i +: 8];
      end
      if (expQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpectedWrite: got write to 0x%08h, expected none", mem_address);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("writeAddr", mem_address, monExp[63:32]);
        checkOutput("writeData", mem_write_data, monExp[31:0]);
      end
    end
  end

  // Runs one load from the vector. Everything is driven on the falling edge;
  // a byte counts as accepted when in_valid and in_ready are both high just
  // before the rising edge. With abortBytes >= 0 it returns as soon as that
  // many bytes have been accepted, leaving the load in flight.
  task automatic applyStimulus(input vec_t v, input int abortBytes);
    int  idx;
    int  doneCyc;
    int  wcBefore;
    bit  acc;
    bit  pulsed;
    bit  finished;
    idx      = 0;
    doneCyc  = -1;
    pulsed   = 1'b0;
    finished = 1'b0;
    wcBefore = writeCount;

    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = v.stream[7:0];

    for (int c = 0; c < 200; c++) begin
      acc = (in_valid && in_ready);
      if (acc && (idx % 4 == 3)) begin
        expQ.push_back({BASE + 32'(4 * (idx / 4)),
                        (idx / 4 == 0) ? v.expWord0 : v.expWord1});
      end
      @(negedge clk);
      start = 1'b0;
      if (acc) idx++;
      if (c == 0) begin
        checkOutput("wordsClearedOnStart", 32'(words_written), 32'd0);
        checkOutput("busyAfterStart", 32'(busy), 32'd1);
`ifdef LOADER_CHECKSUM_EN
        checkOutput("checksumClearedOnStart", checksum, 32'd0);
`endif
      end
      if (abortBytes >= 0 && idx == abortBytes) return;
      if (done === 1'b1) begin
        doneCyc  = c;
        finished = 1'b1;
        break;
      end
      if (v.startPulseAt == idx && !pulsed) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      if (idx < 8 && $urandom_range(99) >= v.gapPct) begin
        in_valid = 1'b1;
        in_data  = v.stream[8*idx +: 8];
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
    end
    in_valid = 1'b0;

    if (!finished) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL loadTimeout: got done=%0b after 200 cycles, expected 1", done);
      return;
    end

    if (v.expDoneCycle >= 0) checkOutput("doneCycle", 32'(doneCyc), 32'(v.expDoneCycle));
    checkOutput("bytesAccepted", 32'(idx), 32'd8);
    checkOutput("writesPerLoad", 32'(writeCount - wcBefore), 32'd2);
    checkOutput("cpuHoldInDone", 32'(cpu_hold), 32'd0);
    checkOutput("busyInDone", 32'(busy), 32'd0);
    checkOutput("inReadyInDone", 32'(in_ready), 32'd0);
    checkOutput("wordsWritten", 32'(words_written), 32'd2);
    checkOutput("lastAddress", mem_address, BASE + 32'd4);
    checkOutput("lastData", mem_write_data, v.expWord1);
    checkOutput("memWord0", readWord(BASE), v.expWord0);
    checkOutput("memWord1", readWord(BASE + 32'd4), v.expWord1);
`ifdef LOADER_CHECKSUM_EN
    checkOutput("checksum", checksum, v.expChecksum);
`endif
  endtask

  // Checks every output against its reset value.
  task automatic checkResetValues();
    checkOutput("rstInReady", 32'(in_ready), 32'd0);
    checkOutput("rstMemWrite", 32'(mem_write), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstCpuHold", 32'(cpu_hold), 32'd1);
    checkOutput("rstAddress", mem_address, BASE);
    checkOutput("rstData", mem_write_data, 32'd0);
    checkOutput("rstWords", 32'(words_written), 32'd0);
`ifdef LOADER_CHECKSUM_EN
    checkOutput("rstChecksum", checksum, 32'd0);
`endif
  endtask

  initial begin
    int wc;

    vecs[0] = '{64'h00000005_44332211, 0,  -1, 10, 32'h44332211, 32'h00000005, 32'h44332216};
    vecs[1] = '{64'h00000005_44332211, 40, -1, -1, 32'h44332211, 32'h00000005, 32'h44332216};
    vecs[2] = '{64'h00000005_44332211, 0,   2, 10, 32'h44332211, 32'h00000005, 32'h44332216};
    vecs[3] = '{64'h00000002_FFFFFFFF, 0,  -1, 10, 32'hFFFFFFFF, 32'h00000002, 32'h00000001};
    vecs[4] = '{64'h01234567_89ABCDEF, 25, -1, -1, 32'h89ABCDEF, 32'h01234567, 32'h8ACF1356};

    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Asynchronous reset asserted between clock edges.
    #3 rst = 1'b1;
    #1 checkResetValues();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idleCpuHold", 32'(cpu_hold), 32'd1);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i], -1);
    end

    // First word of the table byte order must land at the lowest address.
    checkOutput("byte1000", 32'(memModel[BASE]), 32'h000000EF);

    // Reset in the middle of the second word: only the first word is written.
    wc = writeCount;
    applyStimulus(vecs[0], 6);
    rst      = 1'b1;
    in_valid = 1'b0;
    #1 checkResetValues();
    checkOutput("abortWrites", 32'(writeCount - wc), 32'd1);
    checkOutput("abortQueueEmpty", 32'(expQ.size()), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("noWriteInReset", 32'(writeCount - wc), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Fresh load after the abort starts again from BASE.
    applyStimulus(vecs[0], -1);

    checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
